// File: rtl/serial_port_ctrl.sv
// serial_port_ctrl
// 8051 serial-port controller between the SFR bus and a UART RX/TX pair.
// It owns SCON and SBUF, sequences transmits, latches received bytes and
// maintains the TI/RI flags. The interrupt output is the OR of TI and RI.
// Optional feature macro: SERIAL_TX_HOLD_EN adds a one-entry TX holding
// register so an SBUF write during a transmit is queued instead of dropped.
module serial_port_ctrl #(
   parameter logic [7:0] SCON_ADDR = 8'h98,
   parameter logic [7:0] SBUF_ADDR = 8'h99
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_sfr_addr,
   input  logic       i_sfr_wr,
   input  logic [7:0] i_sfr_wdata,
   input  logic       i_sfr_rd,
   output logic [7:0] o_sfr_rdata,
   output logic       o_sfr_hit,
   output logic [7:0] o_tx_data,
   output logic       o_tx_en,
   input  logic       i_tx_done,
   output logic       o_rx_en,
   input  logic       i_rx_done,
   input  logic [7:0] i_rx_data,
   output logic       o_irq
);

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_LOAD = 2'd1,
      TX_BUSY = 2'd2,
      TX_DONE = 2'd3
   } tx_state_t;

   tx_state_t  tx_state_q;
   logic [7:0] tx_data_q;
   logic       tx_en_q;

   logic [7:0] scon_q, scon_d;
   logic [7:0] rx_buf_q, rx_buf_d;

   logic       tx_done_prev_q;
   logic       rx_done_prev_q;

   logic       tx_edge;
   logic       rx_edge;
   logic       scon_wr;
   logic       sbuf_wr;
   logic       ti_set;
   logic       ri_after_cpu;
   logic       rx_accept;

`ifdef SERIAL_TX_HOLD_EN
   logic [7:0] hold_q;
   logic       hold_valid_q;
`endif

   // Reads have no side effects, so the read strobe carries no information here.
   logic       unused_rd;
   assign unused_rd = i_sfr_rd;

   assign scon_wr = i_sfr_wr & (i_sfr_addr == SCON_ADDR);
   assign sbuf_wr = i_sfr_wr & (i_sfr_addr == SBUF_ADDR);

   // Only the rising edge of the UART done lines counts; level holds are harmless.
   assign tx_edge = i_tx_done & ~tx_done_prev_q;
   assign rx_edge = i_rx_done & ~rx_done_prev_q;

   // TI is raised during the single DONE cycle of the transmit sequencer.
   assign ti_set = (tx_state_q == TX_DONE);

   // A CPU write to RI in the same cycle is applied before the receiver looks at RI,
   // so clearing RI together with an rx edge still accepts the byte.
   assign ri_after_cpu = scon_wr ? i_sfr_wdata[0] : scon_q[0];
   assign rx_accept    = rx_edge & scon_q[4] & ~ri_after_cpu;

   // Previous-value registers for the done-line edge detectors.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         tx_done_prev_q <= 1'b0;
         rx_done_prev_q <= 1'b0;
      end else begin
         tx_done_prev_q <= i_tx_done;
         rx_done_prev_q <= i_rx_done;
      end
   end

   // Next SCON / receive buffer: CPU write first, then hardware sets win.
   always_comb begin
      scon_d   = scon_q;
      rx_buf_d = rx_buf_q;
      if (scon_wr) begin
         scon_d = i_sfr_wdata;
      end
      if (ti_set) begin
         scon_d[1] = 1'b1;
      end
      if (rx_accept) begin
         scon_d[0] = 1'b1;
         rx_buf_d  = i_rx_data;
      end
   end

   // SCON and receive buffer storage.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         scon_q   <= 8'h00;
         rx_buf_q <= 8'h00;
      end else begin
         scon_q   <= scon_d;
         rx_buf_q <= rx_buf_d;
      end
   end

   // Transmit sequencer with registered enable and data outputs.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         tx_state_q   <= TX_IDLE;
         tx_data_q    <= 8'h00;
         tx_en_q      <= 1'b0;
`ifdef SERIAL_TX_HOLD_EN
         hold_q       <= 8'h00;
         hold_valid_q <= 1'b0;
`endif
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               if (sbuf_wr) begin
                  tx_data_q  <= i_sfr_wdata;
                  tx_en_q    <= 1'b1;
                  tx_state_q <= TX_LOAD;
               end
            end
            TX_LOAD: begin
               tx_en_q    <= 1'b1;
               tx_state_q <= TX_BUSY;
`ifdef SERIAL_TX_HOLD_EN
               if (sbuf_wr) begin
                  hold_q       <= i_sfr_wdata;
                  hold_valid_q <= 1'b1;
               end
`endif
            end
            TX_BUSY: begin
               if (tx_edge) begin
                  tx_en_q    <= 1'b0;
                  tx_state_q <= TX_DONE;
               end
`ifdef SERIAL_TX_HOLD_EN
               if (sbuf_wr) begin
                  hold_q       <= i_sfr_wdata;
                  hold_valid_q <= 1'b1;
               end
`endif
            end
            TX_DONE: begin
`ifdef SERIAL_TX_HOLD_EN
               // A queued byte launches straight away; a write arriving now
               // either refills the hold or, if the hold is empty, launches itself.
               if (hold_valid_q) begin
                  tx_data_q  <= hold_q;
                  tx_en_q    <= 1'b1;
                  tx_state_q <= TX_LOAD;
                  if (sbuf_wr) begin
                     hold_q <= i_sfr_wdata;
                  end else begin
                     hold_valid_q <= 1'b0;
                  end
               end else if (sbuf_wr) begin
                  tx_data_q  <= i_sfr_wdata;
                  tx_en_q    <= 1'b1;
                  tx_state_q <= TX_LOAD;
               end else begin
                  tx_state_q <= TX_IDLE;
               end
`else
               tx_state_q <= TX_IDLE;
`endif
            end
            default: begin
               tx_en_q    <= 1'b0;
               tx_state_q <= TX_IDLE;
            end
         endcase
      end
   end

   // SFR read mux: combinational from the address, no side effects.
   always_comb begin
      o_sfr_rdata = 8'h00;
      if (i_sfr_addr == SCON_ADDR) begin
         o_sfr_rdata = scon_q;
      end else if (i_sfr_addr == SBUF_ADDR) begin
         o_sfr_rdata = rx_buf_q;
      end
   end

   assign o_sfr_hit = (i_sfr_addr == SCON_ADDR) | (i_sfr_addr == SBUF_ADDR);
   assign o_tx_data = tx_data_q;
   assign o_tx_en   = tx_en_q;
   assign o_rx_en   = scon_q[4];
   assign o_irq     = scon_q[1] | scon_q[0];

endmodule
